// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: capture BRAM -> forward FFT -> spectrum RAM -> inverse FFT.
// Define FFT_SEQ_WATCHDOG_EN to add a cycle watchdog on the FFT unload and IFFT load phases.
module fft_frame_sequencer #(
    parameter int          LOG2N    = 10,
    parameter logic [7:0]  FWD_CFG  = 8'h01,
    parameter logic [7:0]  INV_CFG  = 8'h00,
    parameter logic [15:0] WDOG_CYC = 16'd8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_ready,
    output logic             buf_release,
    output logic             buf_en,
    output logic [LOG2N-1:0] buf_addr,
    output logic [7:0]       fwd_cfg_tdata,
    output logic             fwd_cfg_tvalid,
    input  logic             fwd_cfg_tready,
    output logic             fwd_s_tvalid,
    input  logic             fwd_s_tready,
    output logic             fwd_s_tlast,
    input  logic             fwd_m_tvalid,
    input  logic             fwd_m_tlast,
    input  logic [15:0]      fwd_m_tuser,
    output logic             spec_en,
    output logic             spec_we,
    output logic [LOG2N-1:0] spec_addr,
    output logic [7:0]       inv_cfg_tdata,
    output logic             inv_cfg_tvalid,
    input  logic             inv_cfg_tready,
    output logic             inv_s_tvalid,
    input  logic             inv_s_tready,
    output logic             inv_s_tlast,
    output logic             frame_done,
    output logic             busy,
    output logic             frame_err,
    output logic [2:0]       dbg_state
);

    // AXI-Stream: a beat transfers on a rising edge where tvalid and tready are both high;
    // tvalid, tlast and payload are held unchanged until that edge.

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CONFIG     = 3'd1,
        S_WAIT_FRAME = 3'd2,
        S_FWD_LOAD   = 3'd3,
        S_FWD_UNLOAD = 3'd4,
        S_INV_LOAD   = 3'd5
    } state_t;

    localparam logic [LOG2N:0] N_CNT     = {1'b1, {LOG2N{1'b0}}};
    localparam logic [LOG2N:0] LAST_BEAT = {1'b0, {LOG2N{1'b1}}};
    localparam logic [LOG2N:0] CNT_ONE   = {{LOG2N{1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_next;
    logic           r_fwd_cfg_done;
    logic           r_inv_cfg_done;
    logic [LOG2N:0] r_addr;
    logic [LOG2N:0] r_beat;
    logic [LOG2N:0] r_out_cnt;
    logic           r_s_valid;
    logic           r_buf_release;
    logic           r_frame_done;
    logic           r_frame_err;

    logic           w_in_load;
    logic           w_s_ready;
    logic           w_adv;
    logic           w_issue;
    logic           w_accept;
    logic           w_accept_last;
    logic           w_fwd_acc;
    logic           w_inv_acc;
    logic           w_out_beat;
    logic           w_out_last;
    logic [LOG2N:0] w_out_cnt_next;
    logic           w_len_err;
    logic           w_stray;
    logic           w_wdog_fire;
    logic           w_wdog_trip;
    logic [15:0]    w_unused_tuser;

    assign w_unused_tuser = fwd_m_tuser;

    // Shared 1-latency read pipeline: a read is issued only when the output
    // register is empty or draining, so the RAM output holds during a stall.
    assign w_in_load      = (r_state == S_FWD_LOAD) || (r_state == S_INV_LOAD);
    assign w_s_ready      = (r_state == S_FWD_LOAD) ? fwd_s_tready : inv_s_tready;
    assign w_adv          = ~r_s_valid | w_s_ready;
    assign w_issue        = w_in_load & w_adv & (r_addr != N_CNT);
    assign w_accept       = w_in_load & r_s_valid & w_s_ready;
    assign w_accept_last  = w_accept & (r_beat == LAST_BEAT);

    assign w_out_beat     = (r_state == S_FWD_UNLOAD) & fwd_m_tvalid;
    assign w_out_last     = w_out_beat & fwd_m_tlast;
    assign w_out_cnt_next = r_out_cnt + CNT_ONE;
    assign w_len_err      = w_out_last & (w_out_cnt_next != N_CNT);
    assign w_stray        = fwd_m_tvalid & (r_state != S_FWD_UNLOAD);

    assign w_fwd_acc      = fwd_cfg_tvalid & fwd_cfg_tready;
    assign w_inv_acc      = inv_cfg_tvalid & inv_cfg_tready;

    // A phase that completes on the same cycle the watchdog expires is kept.
    assign w_wdog_trip    = w_wdog_fire & ~w_accept_last & ~w_out_last;

`ifdef FFT_SEQ_WATCHDOG_EN
    logic [15:0] r_wdog;
    logic        w_wdog_state;

    assign w_wdog_state = (r_state == S_FWD_UNLOAD) || (r_state == S_INV_LOAD);
    assign w_wdog_fire  = w_wdog_state && (r_wdog == (WDOG_CYC - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= 16'd0;
        end else if (!w_wdog_state || (w_next != r_state)) begin
            r_wdog <= 16'd0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end
`else
    logic [15:0] w_unused_wdog;

    assign w_unused_wdog = WDOG_CYC;
    assign w_wdog_fire   = 1'b0;
`endif

    always_comb begin
        w_next         = r_state;
        fwd_cfg_tvalid = 1'b0;
        inv_cfg_tvalid = 1'b0;
        buf_en         = 1'b0;
        buf_addr       = '0;
        fwd_s_tvalid   = 1'b0;
        fwd_s_tlast    = 1'b0;
        inv_s_tvalid   = 1'b0;
        inv_s_tlast    = 1'b0;
        spec_en        = 1'b0;
        spec_we        = 1'b0;
        spec_addr      = '0;

        case (r_state)
            S_IDLE: begin
                w_next = S_CONFIG;
            end
            S_CONFIG: begin
                fwd_cfg_tvalid = ~r_fwd_cfg_done;
                inv_cfg_tvalid = ~r_inv_cfg_done;
                if ((r_fwd_cfg_done | (~r_fwd_cfg_done & fwd_cfg_tready)) &&
                    (r_inv_cfg_done | (~r_inv_cfg_done & inv_cfg_tready))) begin
                    w_next = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (frame_ready) begin
                    w_next = S_FWD_LOAD;
                end
            end
            S_FWD_LOAD: begin
                buf_en       = w_issue;
                buf_addr     = r_addr[LOG2N-1:0];
                fwd_s_tvalid = r_s_valid;
                fwd_s_tlast  = r_s_valid & (r_beat == LAST_BEAT);
                if (w_accept_last) begin
                    w_next = S_FWD_UNLOAD;
                end
            end
            S_FWD_UNLOAD: begin
                spec_en   = fwd_m_tvalid;
                spec_we   = fwd_m_tvalid;
                spec_addr = fwd_m_tuser[LOG2N-1:0];
                if (w_out_last) begin
                    w_next = S_INV_LOAD;
                end else if (w_wdog_trip) begin
                    w_next = S_WAIT_FRAME;
                end
            end
            S_INV_LOAD: begin
                spec_en      = w_issue;
                spec_addr    = r_addr[LOG2N-1:0];
                inv_s_tvalid = r_s_valid;
                inv_s_tlast  = r_s_valid & (r_beat == LAST_BEAT);
                if (w_accept_last || w_wdog_trip) begin
                    w_next = S_WAIT_FRAME;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_fwd_cfg_done <= 1'b0;
            r_inv_cfg_done <= 1'b0;
            r_addr         <= '0;
            r_beat         <= '0;
            r_out_cnt      <= '0;
            r_s_valid      <= 1'b0;
            r_buf_release  <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_buf_release <= (r_state == S_FWD_LOAD) & w_accept_last;
            r_frame_done  <= (r_state == S_INV_LOAD) & w_accept_last;

            if (w_fwd_acc) begin
                r_fwd_cfg_done <= 1'b1;
            end
            if (w_inv_acc) begin
                r_inv_cfg_done <= 1'b1;
            end

            if (w_len_err || w_stray || w_wdog_trip) begin
                r_frame_err <= 1'b1;
            end

            if (r_state != S_FWD_UNLOAD) begin
                r_out_cnt <= '0;
            end else if (w_out_beat) begin
                r_out_cnt <= w_out_cnt_next;
            end

            // Counters restart from zero on every entry to a load phase.
            if (!w_in_load) begin
                r_addr    <= '0;
                r_beat    <= '0;
                r_s_valid <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_addr <= r_addr + CNT_ONE;
                end
                if (w_accept) begin
                    r_beat <= r_beat + CNT_ONE;
                end
                if (w_wdog_trip) begin
                    r_s_valid <= 1'b0;
                end else if (w_adv) begin
                    r_s_valid <= w_issue;
                end
            end
        end
    end

    assign fwd_cfg_tdata = FWD_CFG;
    assign inv_cfg_tdata = INV_CFG;
    assign buf_release   = r_buf_release;
    assign frame_done    = r_frame_done;
    assign frame_err     = r_frame_err;
    assign busy          = (r_state != S_IDLE) && (r_state != S_WAIT_FRAME);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: models the capture BRAM, spectrum RAM and FFT output.
module tb_fft_frame_sequencer;

  localparam int LOG2N = 10;
  localparam int N     = 1 << LOG2N;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_FRAME = 3'd2;
  localparam logic [2:0] ST_FWD_LOAD   = 3'd3;
  localparam logic [2:0] ST_FWD_UNLOAD = 3'd4;
  localparam logic [2:0] ST_INV_LOAD   = 3'd5;

  logic             clk;
  logic             rst;
  logic             frame_ready;
  logic             buf_release;
  logic             buf_en;
  logic [LOG2N-1:0] buf_addr;
  logic [7:0]       fwd_cfg_tdata;
  logic             fwd_cfg_tvalid;
  logic             fwd_cfg_tready;
  logic             fwd_s_tvalid;
  logic             fwd_s_tready;
  logic             fwd_s_tlast;
  logic             fwd_m_tvalid;
  logic             fwd_m_tlast;
  logic [15:0]      fwd_m_tuser;
  logic             spec_en;
  logic             spec_we;
  logic [LOG2N-1:0] spec_addr;
  logic [7:0]       inv_cfg_tdata;
  logic             inv_cfg_tvalid;
  logic             inv_cfg_tready;
  logic             inv_s_tvalid;
  logic             inv_s_tready;
  logic             inv_s_tlast;
  logic             frame_done;
  logic             busy;
  logic             frame_err;
  logic [2:0]       dbg_state;

  fft_frame_sequencer #(
    .LOG2N(LOG2N), .FWD_CFG(8'h01), .INV_CFG(8'h00), .WDOG_CYC(16'd100)
  ) dut (
    .clk(clk), .rst(rst), .frame_ready(frame_ready), .buf_release(buf_release),
    .buf_en(buf_en), .buf_addr(buf_addr),
    .fwd_cfg_tdata(fwd_cfg_tdata), .fwd_cfg_tvalid(fwd_cfg_tvalid), .fwd_cfg_tready(fwd_cfg_tready),
    .fwd_s_tvalid(fwd_s_tvalid), .fwd_s_tready(fwd_s_tready), .fwd_s_tlast(fwd_s_tlast),
    .fwd_m_tvalid(fwd_m_tvalid), .fwd_m_tlast(fwd_m_tlast), .fwd_m_tuser(fwd_m_tuser),
    .spec_en(spec_en), .spec_we(spec_we), .spec_addr(spec_addr),
    .inv_cfg_tdata(inv_cfg_tdata), .inv_cfg_tvalid(inv_cfg_tvalid), .inv_cfg_tready(inv_cfg_tready),
    .inv_s_tvalid(inv_s_tvalid), .inv_s_tready(inv_s_tready), .inv_s_tlast(inv_s_tlast),
    .frame_done(frame_done), .busy(busy), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // capture BRAM holds its own address; spectrum RAM is a plain 1-latency RAM
  logic [15:0] buf_dout;
  logic [15:0] spec_mem [0:N-1];
  logic [15:0] spec_wdata;
  logic [15:0] spec_dout;

  always @(posedge clk) begin
    if (buf_en) buf_dout <= 16'(buf_addr);
    if (spec_en && spec_we) spec_mem[spec_addr] <= spec_wdata;
    if (spec_en) spec_dout <= spec_mem[spec_addr];
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int rel_cnt  = 0;
  int done_cnt = 0;
  int wr_cnt [0:N-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    rel_cnt  += int'(buf_release);
    done_cnt += int'(frame_done);
  endtask

  function automatic logic [9:0] bitrev(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  // driver: sink for one input-stream phase; mode 0 = always ready, 1 = toggle, 2 = random
  task automatic load_phase(input bit is_fwd, input int mode);
    int acc;
    int cyc;
    bit rdy;
    bit vld;
    bit lst;
    logic [15:0] got;
    logic [15:0] exp;
    acc = 0;
    cyc = 0;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(is_fwd ? 16'(k) : 16'(bitrev(10'(k))));
    while (acc < N && cyc < 8 * N) begin
      tick();
      cyc++;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2) == 1;
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (is_fwd) begin
        fwd_s_tready = rdy; vld = fwd_s_tvalid; lst = fwd_s_tlast; got = buf_dout;
      end else begin
        inv_s_tready = rdy; vld = inv_s_tvalid; lst = inv_s_tlast; got = spec_dout;
      end
      if (vld && rdy) begin
        exp = exp_q.pop_front();
        check(is_fwd ? "fwd_data" : "inv_data", got, exp);
        check(is_fwd ? "fwd_tlast" : "inv_tlast", lst, acc == N - 1);
        acc++;
      end
    end
    if (acc != N) begin
      check("load_timeout", acc, N);
      exp_q.delete();
    end
    tick();
    if (is_fwd) begin
      check("buf_release_pulse", buf_release, 1);
      check("fwd_tvalid_drop", fwd_s_tvalid, 0);
      check("state_fwd_unload", dbg_state, ST_FWD_UNLOAD);
    end else begin
      check("frame_done_pulse", frame_done, 1);
      check("inv_tvalid_drop", inv_s_tvalid, 0);
      check("state_wait_frame", dbg_state, ST_WAIT_FRAME);
    end
  endtask

  // driver: model FFT emitting nb beats with bit-reversed tuser
  task automatic unload_phase(input int nb);
    logic [15:0] exp;
    for (int a = 0; a < N; a++) wr_cnt[a] = 0;
    exp_q.delete();
    for (int i = 0; i < nb; i++) begin
      tick();
      if (i == 0) check("buf_release_one_cycle", buf_release, 0);
      fwd_m_tvalid = 1'b1;
      fwd_m_tuser  = 16'(bitrev(10'(i)));
      fwd_m_tlast  = (i == nb - 1);
      spec_wdata   = 16'(i);
      exp_q.push_back(16'(bitrev(10'(i))));
      #1;
      if (spec_en && spec_we) begin
        exp = exp_q.pop_front();
        check("spec_addr", 16'(spec_addr), exp);
        wr_cnt[spec_addr]++;
      end else begin
        check("spec_en_we", {spec_en, spec_we}, 2'b11);
      end
    end
    tick();
    fwd_m_tvalid = 1'b0;
    fwd_m_tlast  = 1'b0;
    #1;
    check("spec_we_idle", spec_we, 0);
    check("state_inv_load", dbg_state, ST_INV_LOAD);
    exp_q.delete();
  endtask

  task automatic run_frame(input int fmode, input int imode, input int nb, input bit keep, input bit exp_err);
    int d0;
    int r0;
    int bad;
    d0 = done_cnt;
    r0 = rel_cnt;
    frame_ready = 1'b1;
    tick();
    check("enter_fwd_load", dbg_state, ST_FWD_LOAD);
    check("busy_in_frame", busy, 1);
    if (!keep) frame_ready = 1'b0;
    load_phase(1'b1, fmode);
    unload_phase(nb);
    load_phase(1'b0, imode);
    check("frame_err", frame_err, exp_err);
    if (nb == N) begin
      bad = 0;
      for (int a = 0; a < N; a++) if (wr_cnt[a] != 1) bad++;
      check("spec_write_once", bad, 0);
    end
    check("buf_release_count", rel_cnt - r0, 1);
    check("frame_done_count", done_cnt - d0, 1);
  endtask

  task automatic reset_and_config();
    int reached;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fwd_cfg_tready = 1'b1;
    inv_cfg_tready = 1'b1;
    reached = 0;
    for (int c = 0; c < 10 && reached == 0; c++) begin
      tick();
      if (dbg_state == ST_WAIT_FRAME) reached = 1;
    end
    check("reconfig_wait_frame", reached, 1);
  endtask

  initial begin
    int fcnt;
    int icnt;
    int reached;
    int r0;
    int d0;
    int n_cfg_f;
    int n_cfg_i;
    bit f_pend;
    bit i_pend;

    rst = 1'b1; frame_ready = 1'b0;
    fwd_cfg_tready = 1'b0; inv_cfg_tready = 1'b0;
    fwd_s_tready = 1'b0; inv_s_tready = 1'b0;
    fwd_m_tvalid = 1'b0; fwd_m_tlast = 1'b0; fwd_m_tuser = '0; spec_wdata = '0;

    repeat (3) tick();
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_cfg_valids", {fwd_cfg_tvalid, inv_cfg_tvalid}, 0);
    check("rst_s_valids", {fwd_s_tvalid, fwd_s_tlast, inv_s_tvalid, inv_s_tlast}, 0);
    check("rst_en_we", {buf_en, spec_en, spec_we}, 0);
    check("rst_addrs", {buf_addr, spec_addr}, 0);
    check("rst_pulses_flags", {buf_release, frame_done, busy, frame_err}, 0);
    check("rst_fwd_cfg_tdata", fwd_cfg_tdata, 8'h01);
    check("rst_inv_cfg_tdata", inv_cfg_tdata, 8'h00);

    // config: forward accepted after 3 valid cycles, inverse after 5
    rst = 1'b0;
    fcnt = 0; icnt = 0; reached = 0; f_pend = 0; i_pend = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (f_pend) check("fwd_cfg_drop", fwd_cfg_tvalid, 0);
      if (i_pend) check("inv_cfg_drop", inv_cfg_tvalid, 0);
      f_pend = 0; i_pend = 0;
      if (fwd_cfg_tvalid) begin
        fcnt++;
        check("fwd_cfg_tdata", fwd_cfg_tdata, 8'h01);
      end
      if (inv_cfg_tvalid) icnt++;
      fwd_cfg_tready = fwd_cfg_tvalid && (fcnt >= 3);
      inv_cfg_tready = inv_cfg_tvalid && (icnt >= 5);
      f_pend = fwd_cfg_tready;
      i_pend = inv_cfg_tready;
      if (dbg_state == ST_WAIT_FRAME && reached == 0) reached = c;
    end
    check("fwd_cfg_valid_cycles", fcnt, 3);
    check("inv_cfg_valid_cycles", icnt, 5);
    check("wait_frame_by_cycle7", (reached >= 1) && (reached <= 7), 1);
    check("idle_not_busy", busy, 0);

    // frame 1: always ready, frame_ready dropped, so the sequencer idles afterwards
    run_frame(0, 0, N, 1'b0, 1'b0);
    tick();
    check("stay_wait_frame", dbg_state, ST_WAIT_FRAME);
    check("no_extra_frame_done", frame_done, 0);

    // frames 2 and 3 back to back: toggled forward ready, random inverse ready
    run_frame(1, 0, N, 1'b1, 1'b0);
    run_frame(0, 2, N, 1'b0, 1'b0);

    // frame 4: FFT delivers a short frame
    run_frame(0, 0, 1000, 1'b0, 1'b1);

    // reset mid-frame: abort, no release, config re-sent, error cleared
    frame_ready = 1'b1;
    fwd_s_tready = 1'b1;
    repeat (20) tick();
    check("midframe_in_load", dbg_state, ST_FWD_LOAD);
    r0 = rel_cnt;
    rst = 1'b1;
    tick();
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_outputs", {fwd_s_tvalid, buf_en, busy, frame_err}, 0);
    check("abort_buf_addr", buf_addr, 0);
    rst = 1'b0;
    frame_ready = 1'b0;
    fwd_cfg_tready = 1'b1;
    inv_cfg_tready = 1'b1;
    n_cfg_f = 0; n_cfg_i = 0; reached = 0;
    for (int c = 0; c < 10 && reached == 0; c++) begin
      tick();
      n_cfg_f += int'(fwd_cfg_tvalid);
      n_cfg_i += int'(inv_cfg_tvalid);
      if (dbg_state == ST_WAIT_FRAME) reached = 1;
    end
    check("reconfig_reached", reached, 1);
    check("reconfig_fwd_sent", n_cfg_f, 1);
    check("reconfig_inv_sent", n_cfg_i, 1);
    check("no_release_on_abort", rel_cnt - r0, 0);
    check("err_clear_after_rst", frame_err, 0);

    // stray FFT output while waiting for a frame
    fwd_m_tvalid = 1'b1;
    tick();
    fwd_m_tvalid = 1'b0;
    tick();
    check("stray_m_tvalid_err", frame_err, 1);
    check("stray_state", dbg_state, ST_WAIT_FRAME);

`ifdef FFT_SEQ_WATCHDOG_EN
    // watchdog: FFT never produces output
    reset_and_config();
    d0 = done_cnt;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    load_phase(1'b1, 0);
    reached = 1;
    for (int c = 0; c < 300 && dbg_state == ST_FWD_UNLOAD; c++) begin
      tick();
      if (dbg_state == ST_FWD_UNLOAD) reached++;
    end
    check("wdog_cycles", reached, 100);
    check("wdog_state", dbg_state, ST_WAIT_FRAME);
    check("wdog_err", frame_err, 1);
    check("wdog_valids", {fwd_s_tvalid, inv_s_tvalid, spec_we}, 0);
    repeat (5) tick();
    check("wdog_no_frame_done", done_cnt - d0, 0);
`else
    d0 = done_cnt;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got=%0d exp=done", n_checks);
    $fatal(1, "timeout");
  end

endmodule
